lcd_gfx_sprite_ctrl: RTL and testbench



---
 rtl/lcd_gfx_sprite_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lcd_gfx_sprite_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_gfx_sprite_ctrl.sv
// lcd_gfx_sprite_ctrl: debounced 4-key sprite mover that redraws a 128x64 ST7920 GDRAM frame per move
module lcd_gfx_sprite_ctrl #(
    parameter int EN_HALF  = 2500,
    parameter int DEB_BITS = 20,
    parameter int BLK_W    = 2,
    parameter int BLK_H    = 16,
    parameter int STEP_X   = 1,
    parameter int STEP_Y   = 4,
    parameter int WRAP     = 1,
    parameter int REPEAT   = 0,
    parameter int X0       = 7,
    parameter int Y0       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] data,
    output logic       busy,
    output logic [3:0] pos_x,
    output logic [5:0] pos_y
);
    localparam int MAX_X = 16 - BLK_W;
    localparam int MAX_Y = 64 - BLK_H;
    localparam int CW    = (EN_HALF > 1) ? $clog2(EN_HALF) : 1;

    typedef enum logic [3:0] {IDLE, WAIT_KEY, FUNC0, ENTRY, DISP, FUNC1, SET_Y, SET_X, WRITE, DONE} state_t;

    state_t        state_q;
    logic [3:0]    s1_q, s2_q, db, db_prev_q, pend_q, pend_d, mv;
    logic [CW-1:0] ph_cnt_q;
    logic          phase_q, step, take, emit_q, rs_q, busy_q;
    logic [7:0]    data_q;
    logic [3:0]    pos_x_q, col_q;
    logic [5:0]    pos_y_q, row_q;

    // One step along an axis; opposing keys cancel, edges wrap or clamp.
    function automatic logic [6:0] move(input logic [6:0] p, input logic dec, input logic inc,
                                        input int st, input int mx);
        logic [6:0] s, m;
        s = 7'(st);
        m = 7'(mx);
        return (dec && !inc) ? ((p >= s) ? p - s : ((WRAP != 0) ? m : 7'd0)) :
               (inc && !dec) ? ((p + s <= m) ? p + s : ((WRAP != 0) ? 7'd0 : m)) : p;
    endfunction

    // Pixel byte for a GDRAM cell: solid inside the sprite rectangle.
    function automatic logic [7:0] pix(input logic [3:0] c, input logic [5:0] r,
                                       input logic [3:0] x, input logic [5:0] y);
        logic [6:0] c7, r7, x7, y7;
        c7 = {3'b000, c};
        r7 = {1'b0, r};
        x7 = {3'b000, x};
        y7 = {1'b0, y};
        return (c7 >= x7 && c7 < x7 + 7'(BLK_W) && r7 >= y7 && r7 < y7 + 7'(BLK_H)) ? 8'hFF : 8'h00;
    endfunction

    assign step   = !phase_q && (ph_cnt_q == CW'(EN_HALF - 1));
    assign mv     = pend_q | ((REPEAT != 0) ? db : 4'h0);
    assign take   = step && (state_q == WAIT_KEY) && (|mv);
    assign pend_d = (pend_q & ~{4{take}}) | (db & ~db_prev_q);

    assign rs    = rs_q;
    assign rw    = 1'b0;
    assign en    = phase_q & emit_q;
    assign data  = data_q;
    assign busy  = busy_q;
    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;

    // Two-flop synchroniser for the asynchronous keys (idle high).
    always_ff @(posedge clk) begin
        s1_q <= rst ? 4'hF : {right, left, down, up};
        s2_q <= rst ? 4'hF : s1_q;
    end

    genvar g;
    for (g = 0; g < 4; g++) begin : g_deb
        logic [DEB_BITS-1:0] cnt_q;
        assign db[g] = &cnt_q;
        // Saturating low-time counter; any high sample restarts it.
        always_ff @(posedge clk) begin
            if (rst || s2_q[g]) cnt_q <= '0;
            else if (!db[g]) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Press edges latch into sticky pending bits until the FSM consumes them.
    always_ff @(posedge clk) begin
        db_prev_q <= rst ? 4'h0 : db;
        pend_q    <= rst ? 4'h0 : pend_d;
    end

    // LCD step clock: phase flips every EN_HALF clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cnt_q <= '0;
            phase_q  <= 1'b0;
        end else if (ph_cnt_q == CW'(EN_HALF - 1)) begin
            ph_cnt_q <= '0;
            phase_q  <= ~phase_q;
        end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
        end
    end

    // Frame sequencer: registers the byte for the state it enters on each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            emit_q  <= 1'b0;
            busy_q  <= 1'b1;
            pos_x_q <= 4'(X0);
            pos_y_q <= 6'(Y0);
            row_q   <= '0;
            col_q   <= '0;
        end else if (step) begin
            case (state_q)
                IDLE: begin
                    state_q <= FUNC0;
                    emit_q  <= 1'b1;
                    rs_q    <= 1'b0;
                    data_q  <= 8'h30;
                end
                WAIT_KEY: if (take) begin
                    state_q <= FUNC0;
                    emit_q  <= 1'b1;
                    rs_q    <= 1'b0;
                    data_q  <= 8'h30;
                    busy_q  <= 1'b1;
                    pos_x_q <= 4'(move({3'b000, pos_x_q}, mv[2], mv[3], STEP_X, MAX_X));
                    pos_y_q <= 6'(move({1'b0, pos_y_q}, mv[0], mv[1], STEP_Y, MAX_Y));
                end
                FUNC0: begin
                    state_q <= ENTRY;
                    data_q  <= 8'h06;
                end
                ENTRY: begin
                    state_q <= DISP;
                    data_q  <= 8'h0C;
                end
                DISP: begin
                    state_q <= FUNC1;
                    data_q  <= 8'h36;
                end
                FUNC1: begin
                    state_q <= SET_Y;
                    row_q   <= '0;
                    col_q   <= '0;
                    data_q  <= 8'h80;
                end
                SET_Y: begin
                    state_q <= SET_X;
                    data_q  <= {4'b1000, row_q[5], 3'b000};
                end
                SET_X: begin
                    state_q <= WRITE;
                    rs_q    <= 1'b1;
                    data_q  <= pix(4'd0, row_q, pos_x_q, pos_y_q);
                end
                WRITE: begin
                    if (col_q != 4'd15) begin
                        col_q  <= col_q + 4'd1;
                        data_q <= pix(col_q + 4'd1, row_q, pos_x_q, pos_y_q);
                    end else if (row_q != 6'd63) begin
                        state_q <= SET_Y;
                        rs_q    <= 1'b0;
                        col_q   <= '0;
                        row_q   <= row_q + 6'd1;
                        data_q  <= {3'b100, row_q[4:0] + 5'd1};
                    end else begin
                        state_q <= DONE;
                        emit_q  <= 1'b0;
                        rs_q    <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= WAIT_KEY;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_gfx_sprite_ctrl.sv
// tb_lcd_gfx_sprite_ctrl: directed key vectors with a byte-stream model of the expected frame
module tb_lcd_gfx_sprite_ctrl;
    localparam int BW = 2;
    localparam int BH = 16;

    typedef struct {
        logic [3:0] keys;
        int         hold;
        bit         frame;
        logic [3:0] ex;
        logic [5:0] ey;
    } vec_t;

    logic clk = 0, rst = 1;
    logic up = 1, down = 1, left = 1, right = 1, aux_up = 1;
    logic rs, rw, en, busy;
    logic [7:0] data;
    logic [3:0] pos_x;
    logic [5:0] pos_y;
    logic rs1, rw1, en1, busy1, rs0, rw0, en0, busy0;
    logic [7:0] data1, data0;
    logic [3:0] px1, px0;
    logic [5:0] py1, py0;

    int total = 0, bad = 0;
    int nbytes = 0, nerr = 0, nff = 0, fbase = 0, ebase = 0, ffbase = 0;
    logic [3:0] exp_x = 4'd7;
    logic [5:0] exp_y = 6'd24;
    logic en_p = 0;
    vec_t tbl[5];

    always #5 clk = ~clk;

    lcd_gfx_sprite_ctrl #(.EN_HALF(2), .DEB_BITS(3)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .rs(rs), .rw(rw), .en(en), .data(data), .busy(busy), .pos_x(pos_x), .pos_y(pos_y));

    lcd_gfx_sprite_ctrl #(.EN_HALF(2), .DEB_BITS(3), .Y0(0), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .up(aux_up), .down(1'b1), .left(1'b1), .right(1'b1),
        .rs(rs1), .rw(rw1), .en(en1), .data(data1), .busy(busy1), .pos_x(px1), .pos_y(py1));

    lcd_gfx_sprite_ctrl #(.EN_HALF(2), .DEB_BITS(3), .Y0(0), .WRAP(0)) dut_c (
        .clk(clk), .rst(rst), .up(aux_up), .down(1'b1), .left(1'b1), .right(1'b1),
        .rs(rs0), .rw(rw0), .en(en0), .data(data0), .busy(busy0), .pos_x(px0), .pos_y(py0));

    function automatic logic [8:0] exp_byte(input int idx, input int ex, input int ey);
        int j, r, k, c;
        if (idx < 4) return {1'b0, (idx == 0) ? 8'h30 : (idx == 1) ? 8'h06 : (idx == 2) ? 8'h0C : 8'h36};
        j = idx - 4;
        r = j / 18;
        k = j % 18;
        if (k == 0) return {1'b0, 3'b100, 5'(r)};
        if (k == 1) return {1'b0, 4'b1000, 1'(r >> 5), 3'b000};
        c = k - 2;
        return {1'b1, (c >= ex && c < ex + BW && r >= ey && r < ey + BH) ? 8'hFF : 8'h00};
    endfunction

    always @(negedge clk) begin
        if (en_p && !en) begin
            if ({rs, data} != exp_byte(nbytes - fbase, exp_x, exp_y)) nerr++;
            if (rs && data == 8'hFF) nff++;
            nbytes++;
        end
        en_p = en;
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic clr();
        fbase  = nbytes;
        ebase  = nerr;
        ffbase = nff;
    endtask

    task automatic press(input logic [3:0] m, input int n);
        @(negedge clk);
        {right, left, down, up} = ~m;
        repeat (n) @(negedge clk);
        {right, left, down, up} = 4'hF;
    endtask

    task automatic wait_busy(input logic v, input int budget, input bit mid, output bit ok);
        int hold;
        hold = 0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mid) begin
                if (nbytes - fbase >= 200 && hold < 20) begin
                    right = 0;
                    hold++;
                end else right = 1;
            end
            if (busy == v) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic frame_chk(input string nm, input bit mid);
        bit ok;
        wait_busy(1'b1, 200, 1'b0, ok);
        chk({nm, "_start"}, int'(ok), 1);
        wait_busy(1'b0, 6000, mid, ok);
        chk({nm, "_end"}, int'(ok), 1);
        chk({nm, "_bytes"}, nbytes - fbase, 1156);
        chk({nm, "_err"}, nerr - ebase, 0);
        chk({nm, "_ff"}, nff - ffbase, BW * BH);
        chk({nm, "_x"}, int'(pos_x), int'(exp_x));
        chk({nm, "_y"}, int'(pos_y), int'(exp_y));
    endtask

    initial begin
        bit ok;
        tbl[0] = '{4'b0010, 20, 1'b1, 4'd7, 6'd28};
        tbl[1] = '{4'b0010, 3,  1'b0, 4'd7, 6'd28};
        tbl[2] = '{4'b1110, 20, 1'b1, 4'd7, 6'd32};
        tbl[3] = '{4'b1000, 20, 1'b1, 4'd8, 6'd32};
        tbl[4] = '{4'b0100, 20, 1'b1, 4'd7, 6'd32};

        repeat (3) @(negedge clk);
        chk("rst_en", int'(en), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_rs", int'(rs), 0);
        chk("rst_rw", int'(rw), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_x", int'(pos_x), 7);
        chk("rst_y", int'(pos_y), 24);
        chk("rst_aux_y", int'(py1) + int'(py0), 0);
        rst = 0;
        @(posedge clk); #1;
        clr();
        frame_chk("init", 1'b0);

        for (int i = 0; i < 5; i++) begin
            exp_x = tbl[i].ex;
            exp_y = tbl[i].ey;
            @(posedge clk); #1;
            clr();
            press(tbl[i].keys, tbl[i].hold);
            if (tbl[i].frame) frame_chk($sformatf("vec%0d", i), 1'b0);
            else begin
                repeat (40) @(negedge clk);
                chk($sformatf("vec%0d_idle", i), int'(busy), 0);
                chk($sformatf("vec%0d_bytes", i), nbytes - fbase, 0);
                chk($sformatf("vec%0d_y", i), int'(pos_y), int'(exp_y));
            end
        end

        @(negedge clk);
        aux_up = 0;
        repeat (20) @(negedge clk);
        aux_up = 1;
        chk("aux_clamp_start", int'(busy0), 1);
        chk("aux_wrap_start", int'(busy1), 1);
        ok = 0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy0 && !busy1;
        end
        chk("aux_end", int'(ok), 1);
        chk("aux_wrap_y", int'(py1), 48);
        chk("aux_clamp_y", int'(py0), 0);
        chk("aux_main_idle", int'(busy), 0);

        exp_y = 6'd28;
        @(posedge clk); #1;
        clr();
        press(4'b0001, 20);
        frame_chk("mid_cur", 1'b1);
        exp_x = 4'd8;
        @(posedge clk); #1;
        clr();
        frame_chk("mid_next", 1'b0);

        exp_x = 4'd9;
        @(posedge clk); #1;
        clr();
        press(4'b1000, 20);
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = (nbytes - fbase >= 4 + 30 * 18);
        end
        chk("row30_reached", int'(ok), 1);
        chk("row30_x", int'(pos_x), 9);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_en", int'(en), 0);
        chk("midrst_data", int'(data), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_x", int'(pos_x), 7);
        chk("midrst_y", int'(pos_y), 24);
        @(negedge clk);
        rst = 0;
        exp_x = 4'd7;
        exp_y = 6'd24;
        @(posedge clk); #1;
        clr();
        frame_chk("restart", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
